// File: rtl/norm_pkg.sv
// Shared definitions for the normalizing shifter: shift-mode encoding and
// the width of shift/leading-zero counts.
package norm_pkg;

    typedef enum logic {
        NORM_AUTO     = 1'b0,
        NORM_EXPLICIT = 1'b1
    } norm_mode_e;

    // A count must span 0..frac_w inclusive (all-zero fraction gives frac_w).
    function automatic int norm_cnt_w(input int frac_w);
        return $clog2(frac_w + 1);
    endfunction

endpackage

// File: rtl/norm_shift_pipe_if.sv
// Input/output stream bundle of norm_shift_pipe; slave is the shifter side,
// master is the producer/consumer side.
interface norm_shift_pipe_if
    import norm_pkg::*;
#(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = norm_cnt_w(FRAC_W)
);

    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W-1:0] in_frac;
    logic [EXP_W-1:0]  in_exp;
    logic              in_mode;
    logic [CNT_W-1:0]  in_shamt;

    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] out_frac;
    logic [EXP_W-1:0]  out_exp;
    logic [CNT_W-1:0]  out_shamt;
    logic              out_zero;
    logic              out_uflow;

    modport slave (
        input  in_valid, in_frac, in_exp, in_mode, in_shamt, out_ready,
        output in_ready, out_valid, out_frac, out_exp, out_shamt, out_zero, out_uflow
    );

    modport master (
        output in_valid, in_frac, in_exp, in_mode, in_shamt, out_ready,
        input  in_ready, out_valid, out_frac, out_exp, out_shamt, out_zero, out_uflow
    );

endinterface

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter; an all-zero word counts as FRAC_W.
module norm_lzc
    import norm_pkg::*;
#(
    parameter int FRAC_W = 24,
    parameter int CNT_W  = norm_cnt_w(FRAC_W)
) (
    input  logic [FRAC_W-1:0] frac,
    output logic [CNT_W-1:0]  cnt
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        cnt = CNT_W'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++) begin
            if (frac[i]) begin
                cnt = CNT_W'(FRAC_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizing left shifter with exponent clamp and valid/ready
// flow control on both sides.
module norm_shift_pipe
    import norm_pkg::*;
#(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    norm_shift_pipe_if.slave io
);

    localparam int CNT_W = norm_cnt_w(FRAC_W);
    localparam int CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

    // The exponent never goes below zero: a larger request is cut to in_exp.
    function automatic logic [CNT_W-1:0] clamp_shift(input logic [CNT_W-1:0] req,
                                                     input logic [EXP_W-1:0] e);
        if (CMP_W'(req) > CMP_W'(e)) begin
            return CNT_W'(e);
        end
        return req;
    endfunction

    function automatic logic is_uflow(input logic [CNT_W-1:0] req,
                                      input logic [EXP_W-1:0] e);
        return CMP_W'(req) > CMP_W'(e);
    endfunction

    function automatic logic [FRAC_W-1:0] shift_frac(input logic [FRAC_W-1:0] f,
                                                     input logic [CNT_W-1:0] s);
        if (int'(s) >= FRAC_W) begin
            return '0;
        end
        return f << s;
    endfunction

    logic              vld_p1, vld_p2;
    logic              ld_p1, ld_p2;

    logic [CNT_W-1:0]  lzc_cnt;
    logic [CNT_W-1:0]  req_cnt;
    logic              in_zero;

    logic [FRAC_W-1:0] frac_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic [CNT_W-1:0]  req_p1;
    logic              zero_p1;

    logic [CNT_W-1:0]  s_amt;
    logic [FRAC_W-1:0] frac_nxt;
    logic [EXP_W-1:0]  exp_nxt;
    logic [CNT_W-1:0]  shamt_nxt;
    logic              uflow_nxt;

    logic [FRAC_W-1:0] frac_p2;
    logic [EXP_W-1:0]  exp_p2;
    logic [CNT_W-1:0]  shamt_p2;
    logic              zero_p2;
    logic              uflow_p2;

    assign ld_p2       = !vld_p2 || io.out_ready;
    assign ld_p1       = !vld_p1 || ld_p2;
    assign io.in_ready = ld_p1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld_p1) vld_p1 <= io.in_valid;
            if (ld_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage S1: operands and requested shift ----
    norm_lzc #(.FRAC_W(FRAC_W), .CNT_W(CNT_W)) u_lzc (
        .frac (io.in_frac),
        .cnt  (lzc_cnt)
    );

    assign in_zero = (io.in_mode == NORM_AUTO) && (io.in_frac == '0);
    assign req_cnt = (io.in_mode == NORM_EXPLICIT) ? io.in_shamt : lzc_cnt;

    always_ff @(posedge clk) begin
        if (ld_p1 && io.in_valid) begin
            frac_p1 <= io.in_frac;
            exp_p1  <= io.in_exp;
            req_p1  <= req_cnt;
            zero_p1 <= in_zero;
        end
    end

    // ---- stage S2: clamp, shift, exponent adjust ----
    // A zero fraction in AUTO mode has no leading one, so the clamp is bypassed.
    always_comb begin
        s_amt     = clamp_shift(req_p1, exp_p1);
        frac_nxt  = shift_frac(frac_p1, s_amt);
        exp_nxt   = exp_p1 - EXP_W'(s_amt);
        shamt_nxt = s_amt;
        uflow_nxt = is_uflow(req_p1, exp_p1);
        if (zero_p1) begin
            frac_nxt  = '0;
            exp_nxt   = '0;
            shamt_nxt = CNT_W'(FRAC_W);
            uflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frac_p2  <= '0;
            exp_p2   <= '0;
            shamt_p2 <= '0;
            zero_p2  <= 1'b0;
            uflow_p2 <= 1'b0;
        end else if (ld_p2 && vld_p1) begin
            frac_p2  <= frac_nxt;
            exp_p2   <= exp_nxt;
            shamt_p2 <= shamt_nxt;
            zero_p2  <= zero_p1;
            uflow_p2 <= uflow_nxt;
        end
    end

    assign io.out_valid = vld_p2 && !rst;
    assign io.out_frac  = frac_p2;
    assign io.out_exp   = exp_p2;
    assign io.out_shamt = shamt_p2;
    assign io.out_zero  = zero_p2;
    assign io.out_uflow = uflow_p2;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Bench for norm_shift_pipe: directed vector table, backpressure and
// mid-stream reset sequences, then randomized traffic against a reference model.
module tb_norm_shift_pipe;
    import norm_pkg::*;

    typedef struct packed {
        logic [23:0] frac;
        logic [7:0]  exp;
        logic [4:0]  shamt;
        logic        zero;
        logic        uflow;
    } res_t;

    typedef struct {
        logic        mode;
        logic [23:0] frac;
        logic [7:0]  exp;
        logic [4:0]  shamt;
        res_t        want;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    norm_shift_pipe_if #(.FRAC_W(24), .EXP_W(8)) io ();

    norm_shift_pipe #(.FRAC_W(24), .EXP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    res_t q[$];
    bit   hold_pending = 1'b0;
    res_t held;
    bit   last_in_xfer = 1'b0;
    int   got = 0;
    int   full_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Reference: normalize by the position of the leading one, limited by the exponent.
    function automatic res_t model(input logic mode, input logic [23:0] f,
                                   input logic [7:0] e, input logic [4:0] sh);
        res_t r;
        int   req;
        int   s;
        if (!mode && f == 24'h0) begin
            r.frac = 24'h0; r.exp = 8'h0; r.shamt = 5'd24; r.zero = 1'b1; r.uflow = 1'b0;
            return r;
        end
        req = mode ? int'(sh) : 24 - $clog2(int'(f) + 1);
        s   = (req > int'(e)) ? int'(e) : req;
        r.frac  = 24'(longint'(f) << s);
        r.exp   = 8'(int'(e) - s);
        r.shamt = 5'(s);
        r.zero  = 1'b0;
        r.uflow = (req > int'(e));
        return r;
    endfunction

    function automatic vec_t mk(input logic mode, input logic [23:0] f, input logic [7:0] e,
                                input logic [4:0] sh, input logic [23:0] wf, input logic [7:0] we,
                                input logic [4:0] ws, input logic wz, input logic wu);
        vec_t v;
        v.mode = mode; v.frac = f; v.exp = e; v.shamt = sh;
        v.want.frac = wf; v.want.exp = we; v.want.shamt = ws; v.want.zero = wz; v.want.uflow = wu;
        return v;
    endfunction

    function automatic res_t cur_out();
        return {io.out_frac, io.out_exp, io.out_shamt, io.out_zero, io.out_uflow};
    endfunction

    task automatic tick();
        res_t w;
        @(negedge clk);
        last_in_xfer = 1'b0;
        if (mon_en) begin
            if (hold_pending) begin
                chk("hold_stable", 64'(cur_out()), 64'(held));
                chk("hold_valid", 64'(io.out_valid), 64'(1));
            end
            chk("in_ready_model", 64'(io.in_ready), 64'(!(q.size() == 2 && !io.out_ready)));
            if (q.size() == 2 && !io.out_ready) full_seen++;
            chk("no_stale", 64'(io.out_valid && q.size() == 0), 64'(0));
            if (io.out_valid && io.out_ready && q.size() > 0) begin
                w = q.pop_front();
                chk("stream_result", 64'(cur_out()), 64'(w));
                got++;
            end
            hold_pending = io.out_valid && !io.out_ready;
            held = cur_out();
            if (io.in_valid && io.in_ready) begin
                q.push_back(model(io.in_mode, io.in_frac, io.in_exp, io.in_shamt));
                last_in_xfer = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mode, input logic [23:0] f, input logic [7:0] e,
                         input logic [4:0] sh);
        io.in_mode = mode; io.in_frac = f; io.in_exp = e; io.in_shamt = sh;
    endtask

    vec_t        tbl[9];
    logic        bp_mode[5];
    logic [23:0] bp_frac[5];
    logic [7:0]  bp_exp[5];
    logic [4:0]  bp_sh[5];

    initial begin
        int k;
        int low_left;
        bit first_seen;
        int stale;
        logic [23:0] tf;

        tbl[0] = mk(1'b0, 24'h000400, 8'd100, 5'd0, 24'h800000, 8'd87, 5'd13, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 24'h000000, 8'd50,  5'd0, 24'h000000, 8'd0,  5'd24, 1'b1, 1'b0);
        tbl[2] = mk(1'b0, 24'h000001, 8'd5,   5'd0, 24'h000020, 8'd0,  5'd5,  1'b0, 1'b1);
        tbl[3] = mk(1'b1, 24'h123456, 8'd10,  5'd3, 24'h91A2B0, 8'd7,  5'd3,  1'b0, 1'b0);
        tbl[4] = mk(1'b1, 24'hABCDEF, 8'd200, 5'd31, 24'h000000, 8'd169, 5'd31, 1'b0, 1'b0);
        tbl[5] = mk(1'b0, 24'h800000, 8'd0,   5'd0, 24'h800000, 8'd0,  5'd0,  1'b0, 1'b0);
        tbl[6] = mk(1'b0, 24'h000400, 8'd0,   5'd0, 24'h000400, 8'd0,  5'd0,  1'b0, 1'b1);
        tbl[7] = mk(1'b1, 24'h000000, 8'd5,   5'd2, 24'h000000, 8'd3,  5'd2,  1'b0, 1'b0);
        tbl[8] = mk(1'b1, 24'h000001, 8'd1,   5'd4, 24'h000002, 8'd0,  5'd1,  1'b0, 1'b1);

        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        drive(1'b0, 24'h0, 8'h0, 5'h0);

        // Reset state
        tick();
        chk("rst_in_ready", 64'(io.in_ready), 64'(0));
        chk("rst_out_valid", 64'(io.out_valid), 64'(0));
        chk("rst_out_word", 64'(cur_out()), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(io.in_ready), 64'(1));

        // Directed vectors, one at a time, checking the two-cycle latency
        io.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            io.in_valid = 1'b1;
            drive(tbl[i].mode, tbl[i].frac, tbl[i].exp, tbl[i].shamt);
            chk($sformatf("vec%0d_in_ready", i), 64'(io.in_ready), 64'(1));
            tick();
            io.in_valid = 1'b0;
            chk($sformatf("vec%0d_not_early", i), 64'(io.out_valid), 64'(0));
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(io.out_valid), 64'(1));
            chk($sformatf("vec%0d_result", i), 64'(cur_out()), 64'(tbl[i].want));
        end
        tick();

        // Backpressure: five back-to-back words, consumer stalls four cycles
        for (int i = 0; i < 5; i++) begin
            bp_mode[i] = 1'($urandom);
            bp_frac[i] = 24'($urandom) >> $urandom_range(0, 23);
            bp_exp[i]  = 8'($urandom_range(0, 255));
            bp_sh[i]   = 5'($urandom_range(0, 31));
        end
        q.delete();
        hold_pending = 1'b0;
        got = 0;
        full_seen = 0;
        mon_en = 1'b1;
        k = 0;
        low_left = 0;
        first_seen = 1'b0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (!first_seen && io.out_valid) begin
                first_seen = 1'b1;
                low_left = 4;
            end
            io.out_ready = (low_left == 0);
            if (low_left > 0) low_left--;
            io.in_valid = (k < 5);
            if (k < 5) drive(bp_mode[k], bp_frac[k], bp_exp[k], bp_sh[k]);
            tick();
            if (last_in_xfer) k++;
        end
        io.in_valid = 1'b0;
        chk("bp_all_received", 64'(got), 64'(5));
        chk("bp_queue_empty", 64'(q.size()), 64'(0));
        chk("bp_full_seen", 64'(full_seen > 0), 64'(1));
        mon_en = 1'b0;

        // Reset with both stages holding words
        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        drive(1'b0, 24'h00F000, 8'd40, 5'd0);
        tick();
        drive(1'b1, 24'h0000FF, 8'd40, 5'd8);
        tick();
        io.in_valid = 1'b0;
        chk("mid_full_valid", 64'(io.out_valid), 64'(1));
        chk("mid_full_ready", 64'(io.in_ready), 64'(0));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(io.out_valid), 64'(0));
        rst = 1'b0;
        #1;
        chk("mid_ready_after", 64'(io.in_ready), 64'(1));
        io.out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (io.out_valid) stale++;
        end
        chk("mid_no_stale", 64'(stale), 64'(0));

        // Randomized traffic with random stalls on both sides
        q.delete();
        hold_pending = 1'b0;
        got = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            io.in_valid  = ($urandom_range(0, 9) < 7);
            io.out_ready = ($urandom_range(0, 9) < 7);
            tf = 24'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 9) == 0) tf = 24'h0;
            drive(1'($urandom), tf,
                  ($urandom_range(0, 9) < 3) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255)),
                  5'($urandom_range(0, 31)));
            tick();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            tick();
        end
        chk("rand_drained", 64'(q.size()), 64'(0));
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
